// File: rtl/fetch_stage_pkg.sv
// Shared widths, reset constants and fetch FSM encoding for the IF stage.
package fetch_stage_pkg;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEF  = 32'hBFC0_0000;
  localparam logic [INST_W-1:0] NOP_INSTR_DEF = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] PC_STEP       = 32'd4;

  // IDLE: one cycle after reset release, no request.
  // REQ : normal fetching at pcF.
  // DROP: a killed request is still outstanding at the old address; its
  //       response is swallowed before fetching at the redirected pcF.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } fetchState_t;

  // Redirect targets are forced onto a word boundary; no exception here.
  function automatic logic [ADDR_W-1:0] wordAlign(input logic [ADDR_W-1:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load, otherwise a bubble.
module fetch_stage_if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [INST_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall,
  input  logic              load,
  input  logic [INST_W-1:0] instrIn,
  input  logic [ADDR_W-1:0] pcIn,
  output logic [INST_W-1:0] instrD,
  output logic [ADDR_W-1:0] pcD,
  output logic [ADDR_W-1:0] pc_plus4D,
  output logic              validD
);

  // Register update: flush > stall (hold) > load > bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instrD    <= NOP_INSTR;
      pcD       <= '0;
      pc_plus4D <= '0;
      validD    <= 1'b0;
    end else if (flush) begin
      instrD    <= NOP_INSTR;
      pcD       <= '0;
      pc_plus4D <= '0;
      validD    <= 1'b0;
    end else if (!stall) begin
      if (load) begin
        instrD    <= instrIn;
        pcD       <= pcIn;
        pc_plus4D <= pcIn + PC_STEP;
        validD    <= 1'b1;
      end else begin
        instrD    <= NOP_INSTR;
        pcD       <= '0;
        pc_plus4D <= '0;
        validD    <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, single-outstanding instruction fetch, one-entry
// hold buffer for responses that arrive while ID is stalled, and IF/ID.
//
// Memory handshake: inst_req is the valid, inst_ready the ready. A transfer
// happens only on a cycle with inst_req && inst_ready. Once inst_req is high
// and inst_ready is low, inst_req and inst_addr stay unchanged until the
// transfer completes, even if the fetch has been killed in the meantime.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [INST_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallF,
  input  logic              stallD,
  input  logic              flushD,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_ready,
  input  logic [INST_W-1:0] inst_rdata,
  output logic              fetch_stall,
  output logic [ADDR_W-1:0] pcF,
  output logic [INST_W-1:0] instrD,
  output logic [ADDR_W-1:0] pcD,
  output logic [ADDR_W-1:0] pc_plus4D,
  output logic              validD,
  output fetchState_t       dbgState
);

  fetchState_t       state;
  fetchState_t       stateNext;
  logic [ADDR_W-1:0] dropAddr;

  // pcDone: the instruction at pcF was already fetched while stallF held the
  // PC, so pcF must advance (not refetch) once stallF drops.
  logic              pcDone;

  logic              bufValid;
  logic [INST_W-1:0] bufInstr;
  logic [ADDR_W-1:0] bufPc;

  logic              reqIssue;
  logic              redirTaken;
  logic [ADDR_W-1:0] redirTarget;
  logic              kill;
  logic              accept;
  logic              keepTarget;
  logic              keepResp;
  logic              idLoad;
  logic [INST_W-1:0] idInstr;
  logic [ADDR_W-1:0] idPc;

  // A new fetch only starts with an empty hold buffer, so an accepted
  // response always has a place to go and a pending request is never retracted.
  assign reqIssue    = (state == ST_REQ) && !bufValid && !pcDone;
  assign accept      = reqIssue && inst_ready;
  assign redirTaken  = redirect_valid && !stallD;
  assign redirTarget = wordAlign(redirect_pc);
  assign kill        = flushD || redirTaken;
  // A response landing on the same edge as a redirect survives only when it
  // is the redirect target itself and ID is not being flushed.
  assign keepTarget  = accept && redirTaken && !flushD && (pcF == redirTarget);
  assign keepResp    = (accept && !kill) || keepTarget;

  assign fetch_stall = inst_req && !inst_ready;
  assign dbgState    = state;

  // Next-state and memory request outputs.
  always_comb begin
    stateNext = state;
    inst_req  = 1'b0;
    inst_addr = pcF;
    case (state)
      ST_IDLE: stateNext = ST_REQ;
      ST_REQ: begin
        inst_req = reqIssue;
        if (reqIssue && !inst_ready && kill) stateNext = ST_DROP;
      end
      ST_DROP: begin
        inst_req  = 1'b1;
        inst_addr = dropAddr;
        if (inst_ready) stateNext = ST_REQ;
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  // State register; remembers the abandoned address while its response drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      dropAddr <= RESET_PC;
    end else begin
      state <= stateNext;
      if (state == ST_REQ && reqIssue && !inst_ready && kill) dropAddr <= pcF;
    end
  end

  // PC update: redirect, then flush, then accepted fetch, then deferred advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcF    <= RESET_PC;
      pcDone <= 1'b0;
    end else if (redirTaken) begin
      pcF    <= (keepTarget && !stallF) ? redirTarget + PC_STEP : redirTarget;
      pcDone <= keepTarget && stallF;
    end else if (flushD) begin
      pcDone <= 1'b0;
    end else if (accept) begin
      if (stallF) pcDone <= 1'b1;
      else        pcF    <= pcF + PC_STEP;
    end else if (pcDone && !stallF) begin
      pcF    <= pcF + PC_STEP;
      pcDone <= 1'b0;
    end
  end

  // Hold buffer: captures a kept response while ID is stalled, drains when it is not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bufValid <= 1'b0;
      bufInstr <= '0;
      bufPc    <= '0;
    end else if (flushD) begin
      bufValid <= 1'b0;
    end else if (keepResp && stallD) begin
      bufValid <= 1'b1;
      bufInstr <= inst_rdata;
      bufPc    <= pcF;
    end else if (!stallD) begin
      bufValid <= 1'b0;
    end
  end

  // Buffered data is older than anything fresh, so it goes to ID first.
  assign idLoad  = bufValid || keepResp;
  assign idInstr = bufValid ? bufInstr : inst_rdata;
  assign idPc    = bufValid ? bufPc : pcF;

  fetch_stage_if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk       (clk),
    .rst       (rst),
    .flush     (flushD),
    .stall     (stallD),
    .load      (idLoad),
    .instrIn   (idInstr),
    .pcIn      (idPc),
    .instrD    (instrD),
    .pcD       (pcD),
    .pc_plus4D (pc_plus4D),
    .validD    (validD)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run checked
// against a program-order model of the instruction stream seen by ID.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallF, stallD, flushD, redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ready;
  logic [31:0] inst_rdata;
  logic        fetch_stall;
  logic [31:0] pcF, instrD, pcD, pc_plus4D;
  logic        validD;
  fetchState_t dbgState;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stallF         (stallF),
    .stallD         (stallD),
    .flushD         (flushD),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_req       (inst_req),
    .inst_addr      (inst_addr),
    .inst_ready     (inst_ready),
    .inst_rdata     (inst_rdata),
    .fetch_stall    (fetch_stall),
    .pcF            (pcF),
    .instrD         (instrD),
    .pcD            (pcD),
    .pc_plus4D      (pc_plus4D),
    .validD         (validD),
    .dbgState       (dbgState)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Instruction memory contents: a fixed, address-dependent word.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
  endfunction

  assign inst_rdata = memWord(inst_addr);

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(negedge clk);
  endtask

  task automatic clearInputs();
    stallF = 1'b0; stallD = 1'b0; flushD = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
  endtask

  // Leaves the bench on the first negedge after release: FSM now in REQ.
  task automatic doReset();
    clearInputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check32("rst_pcF", pcF, RST_PC);
    check32("rst_req", 32'(inst_req), 0);
    check32("rst_fstall", 32'(fetch_stall), 0);
    check32("rst_instrD", instrD, NOP);
    check32("rst_pcD", pcD, 0);
    check32("rst_plus4D", pc_plus4D, 0);
    check32("rst_validD", 32'(validD), 0);
    check32("rst_state", 32'(dbgState), 32'(ST_IDLE));
    rst = 1'b0;
    @(negedge clk);
  endtask

  logic [31:0] expNext, prevAddr, expPc;
  logic        prevPending;
  int          consumed;
  int          r;

  initial begin
    // 1: free-running fetch from reset
    doReset();
    exp_q = {RST_PC, RST_PC + 4, RST_PC + 8};
    inst_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check32("t1_req", 32'(inst_req), 1);
      check32("t1_addr", inst_addr, RST_PC + 32'(4 * k));
      if (k == 0) begin
        check32("t1_valid0", 32'(validD), 0);
      end else begin
        expPc = exp_q.pop_front();
        check32("t1_validD", 32'(validD), 1);
        check32("t1_pcD", pcD, expPc);
        check32("t1_plus4D", pc_plus4D, expPc + 4);
        check32("t1_instrD", instrD, memWord(expPc));
      end
      step();
    end

    // 2: memory waits three cycles at BFC00004
    doReset();
    inst_ready = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      inst_ready = 1'b0;
      #1;
      check32("t2_req", 32'(inst_req), 1);
      check32("t2_addr", inst_addr, RST_PC + 4);
      check32("t2_fstall", 32'(fetch_stall), 1);
      step();
    end
    inst_ready = 1'b1;
    step();
    check32("t2_pcD", pcD, RST_PC + 4);
    check32("t2_instrD", instrD, memWord(RST_PC + 4));
    check32("t2_validD", 32'(validD), 1);

    // 3: response arrives during a two-cycle full stall
    doReset();
    inst_ready = 1'b1;
    step();
    stallF = 1'b1; stallD = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      check32("t3_hold_pcD", pcD, RST_PC);
      check32("t3_hold_valid", 32'(validD), 1);
      check32("t3_hold_pcF", pcF, RST_PC + 4);
      check32("t3_hold_req", 32'(inst_req), 0);
      if (k == 0) step();
    end
    stallF = 1'b0; stallD = 1'b0;
    step();
    check32("t3_rel_pcD", pcD, RST_PC + 4);
    check32("t3_rel_instrD", instrD, memWord(RST_PC + 4));
    check32("t3_rel_addr", inst_addr, RST_PC + 8);
    step();
    check32("t3_next_pcD", pcD, RST_PC + 8);

    // 4: redirect to 0x80 while the fetch at 0x10 is pending
    doReset();
    inst_ready = 1'b1; redirect_valid = 1'b1; flushD = 1'b1; redirect_pc = 32'h13;
    step();
    check32("t4_align_addr", inst_addr, 32'h10);
    check32("t4_first_valid", 32'(validD), 0);
    redirect_valid = 1'b0; flushD = 1'b0; inst_ready = 1'b0;
    step();
    redirect_valid = 1'b1; flushD = 1'b1; redirect_pc = 32'h80;
    #1;
    check32("t4_pending", 32'(fetch_stall), 1);
    step();
    check32("t4_drop_state", 32'(dbgState), 32'(ST_DROP));
    check32("t4_drop_req", 32'(inst_req), 1);
    check32("t4_drop_addr", inst_addr, 32'h10);
    check32("t4_drop_pcF", pcF, 32'h80);
    check32("t4_drop_valid", 32'(validD), 0);
    redirect_valid = 1'b0; flushD = 1'b0; inst_ready = 1'b1;
    step();
    check32("t4_discard_valid", 32'(validD), 0);
    check32("t4_new_addr", inst_addr, 32'h80);
    step();
    check32("t4_pcD", pcD, 32'h80);
    check32("t4_instrD", instrD, memWord(32'h80));

    // 5: flush and stall on the same edge
    doReset();
    inst_ready = 1'b1;
    step();
    check32("t5_pre_valid", 32'(validD), 1);
    flushD = 1'b1; stallD = 1'b1; stallF = 1'b1;
    step();
    check32("t5_instrD", instrD, NOP);
    check32("t5_validD", 32'(validD), 0);

    // 6: asynchronous reset in the middle of a pending fetch
    doReset();
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0; stallD = 1'b1;
    step();
    #3 rst = 1'b1;
    #1;
    check32("t6_pcF", pcF, RST_PC);
    check32("t6_req", 32'(inst_req), 0);
    check32("t6_validD", 32'(validD), 0);
    check32("t6_instrD", instrD, NOP);
    @(negedge clk);
    clearInputs();
    rst = 1'b0;
    inst_ready = 1'b1;
    step();
    check32("t6_first_req", 32'(inst_req), 1);
    check32("t6_first_addr", inst_addr, RST_PC);

    // 7: PC wraps past the top of the address space
    doReset();
    inst_ready = 1'b1; redirect_valid = 1'b1; flushD = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0; flushD = 1'b0;
    step();
    step();
    check32("t7_pcD", pcD, 32'hFFFF_FFFC);
    check32("t7_plus4D", pc_plus4D, 32'h0);
    check32("t7_pcF", pcF, 32'h0);
    step();
    check32("t7_wrap_pcD", pcD, 32'h0);

    // Randomized run: ID must see the program-order stream exactly once.
    doReset();
    expNext = RST_PC; prevPending = 1'b0; prevAddr = '0; consumed = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (prevPending) begin
        check32("hs_req", 32'(inst_req), 1);
        check32("hs_addr", inst_addr, prevAddr);
      end
      if (validD) begin
        check32("rnd_instrD", instrD, memWord(pcD));
        check32("rnd_plus4D", pc_plus4D, pcD + 32'd4);
      end
      inst_ready     = ($urandom_range(0, 9) < 7);
      stallD         = ($urandom_range(0, 9) < 2);
      stallF         = stallD || ($urandom_range(0, 9) == 0);
      redirect_valid = 1'b0;
      flushD         = 1'b0;
      redirect_pc    = $urandom;
      r              = $urandom_range(0, 19);
      if (r == 0 && !stallD) begin
        redirect_valid = 1'b1;
        flushD         = 1'b1;
        if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFE0 | 32'($urandom_range(0, 31));
        else                           redirect_pc = 32'($urandom_range(0, 255));
      end else if (r == 1 && stallD) begin
        redirect_valid = 1'b1;
      end
      #1;
      check32("rnd_fstall", 32'(fetch_stall), 32'(inst_req && !inst_ready));
      if (flushD && redirect_valid) begin
        expNext = {redirect_pc[31:2], 2'b00};
      end else if (validD && !stallD) begin
        check32("rnd_order", pcD, expNext);
        expNext = pcD + 32'd4;
        consumed++;
      end
      prevPending = inst_req && !inst_ready;
      prevAddr    = inst_addr;
      step();
    end
    check32("rnd_progress", 32'(consumed > 300), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
